// File: rtl/aurora_img_pkg.sv
// Shared definitions for the Aurora camera image link (packetizer and depacketizer).
// Header layout, default frame geometry and the receive FSM state type.
package aurora_img_pkg;

    localparam logic [15:0] SYNC_WORD = 16'h5AA5;

    localparam int unsigned SYNC_HI = 31;
    localparam int unsigned SYNC_LO = 16;
    localparam int unsigned FS_BIT  = 15;
    localparam int unsigned LINE_HI = 10;
    localparam int unsigned LINE_LO = 0;
    localparam int unsigned LINE_W  = LINE_HI - LINE_LO + 1;

    localparam int unsigned DEF_H_PIXELS = 640;
    localparam int unsigned DEF_V_LINES  = 480;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DROP
    } rx_state_t;

endpackage

// File: rtl/img_hdr_check.sv
// Line-packet header decode plus the expected-line tracker that raises seq_err
// when a non-frame-start header arrives out of order.
module img_hdr_check #(
    parameter logic [15:0] SYNC_WORD = aurora_img_pkg::SYNC_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] hdr,
    input  logic        accept,
    input  logic        line_good,
    input  logic        last_line,
    input  logic [10:0] done_line,
    output logic        sync_ok,
    output logic        fs_flag,
    output logic [10:0] line_idx,
    output logic        seq_err
);
    import aurora_img_pkg::*;

    logic [10:0] exp_line;
    logic        unused_rsvd;

    assign sync_ok     = (hdr[SYNC_HI:SYNC_LO] == SYNC_WORD);
    assign fs_flag     = hdr[FS_BIT];
    assign line_idx    = hdr[LINE_HI:LINE_LO];
    assign unused_rsvd = ^hdr[FS_BIT-1:LINE_HI+1];

    // Both the frame-start force and the mismatch resync leave expected = received index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_line <= '0;
            seq_err  <= 1'b0;
        end else begin
            seq_err <= accept && !fs_flag && (line_idx != exp_line);
            if (accept)
                exp_line <= line_idx;
            else if (line_good)
                exp_line <= last_line ? '0 : done_line + 11'd1;
        end
    end

endmodule

// File: rtl/aurora_img_depkt.sv
// Aurora RX image depacketizer: strips line headers, emits RGB565 pixel pairs with markers.
// Optional statistics counters are compiled in with `define ARX_STATS_EN.
module aurora_img_depkt #(
    parameter int unsigned H_PIXELS  = aurora_img_pkg::DEF_H_PIXELS,
    parameter int unsigned V_LINES   = aurora_img_pkg::DEF_V_LINES,
    parameter logic [15:0] SYNC_WORD = aurora_img_pkg::SYNC_WORD
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] s_axi_rx_tdata,
    input  logic [3:0]  s_axi_rx_tkeep,
    input  logic        s_axi_rx_tlast,
    input  logic        s_axi_rx_tvalid,
    input  logic        i_channel_up,
    output logic [31:0] o_pix_data,
    output logic        o_pix_vld,
    output logic [10:0] o_line_idx,
    output logic        o_frame_start,
    output logic        o_line_end,
    output logic        o_frame_done,
    output logic        o_hdr_err,
    output logic        o_len_err,
    output logic        o_seq_err
`ifdef ARX_STATS_EN
    ,
    input  logic        i_stats_clr,
    output logic [31:0] o_pkt_cnt,
    output logic [31:0] o_err_cnt
`endif
);
    import aurora_img_pkg::*;

    localparam int unsigned H_WORDS = H_PIXELS / 2;
    localparam int unsigned WCNT_W  = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(H_WORDS - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_LINES - 1);

    rx_state_t         state, state_d;
    logic [WCNT_W-1:0] wcnt, wcnt_d;
    logic [10:0]       cur_line, cur_line_d;
    logic              cur_fs, cur_fs_d;

    logic pix_vld_d, frame_start_d, line_end_d, frame_done_d, hdr_err_d, len_err_d;
    logic accept, line_good;
    logic sync_ok, hdr_fs;
    logic [10:0] hdr_line;

    img_hdr_check #(
        .SYNC_WORD(SYNC_WORD)
    ) u_hdr (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .hdr       (s_axi_rx_tdata),
        .accept    (accept),
        .line_good (line_good),
        .last_line (cur_line == LAST_LINE),
        .done_line (cur_line),
        .sync_ok   (sync_ok),
        .fs_flag   (hdr_fs),
        .line_idx  (hdr_line),
        .seq_err   (o_seq_err)
    );

    always_comb begin
        state_d       = state;
        wcnt_d        = wcnt;
        cur_line_d    = cur_line;
        cur_fs_d      = cur_fs;
        pix_vld_d     = 1'b0;
        frame_start_d = 1'b0;
        line_end_d    = 1'b0;
        frame_done_d  = 1'b0;
        hdr_err_d     = 1'b0;
        len_err_d     = 1'b0;
        accept        = 1'b0;
        line_good     = 1'b0;

        // Losing the channel abandons the packet silently; no beat is consumed.
        if (!i_channel_up) begin
            state_d = IDLE;
        end else if (s_axi_rx_tvalid) begin
            case (state)
                IDLE: begin
                    if (sync_ok && !s_axi_rx_tlast) begin
                        accept     = 1'b1;
                        cur_line_d = hdr_line;
                        cur_fs_d   = hdr_fs;
                        wcnt_d     = '0;
                        state_d    = PAYLOAD;
                    end else begin
                        hdr_err_d = 1'b1;
                        state_d   = s_axi_rx_tlast ? IDLE : DROP;
                    end
                end
                PAYLOAD: begin
                    if (s_axi_rx_tkeep != 4'hF) begin
                        len_err_d = 1'b1;
                        state_d   = s_axi_rx_tlast ? IDLE : DROP;
                    end else begin
                        pix_vld_d     = 1'b1;
                        frame_start_d = (wcnt == '0) && cur_fs && (cur_line == '0);
                        if (wcnt == LAST_WORD) begin
                            if (s_axi_rx_tlast) begin
                                line_end_d   = 1'b1;
                                line_good    = 1'b1;
                                frame_done_d = (cur_line == LAST_LINE);
                                state_d      = IDLE;
                            end else begin
                                len_err_d = 1'b1;
                                state_d   = DROP;
                            end
                        end else if (s_axi_rx_tlast) begin
                            len_err_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            wcnt_d = wcnt + 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (s_axi_rx_tlast)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            wcnt          <= '0;
            cur_line      <= '0;
            cur_fs        <= 1'b0;
            o_pix_data    <= '0;
            o_pix_vld     <= 1'b0;
            o_line_idx    <= '0;
            o_frame_start <= 1'b0;
            o_line_end    <= 1'b0;
            o_frame_done  <= 1'b0;
            o_hdr_err     <= 1'b0;
            o_len_err     <= 1'b0;
        end else begin
            state         <= state_d;
            wcnt          <= wcnt_d;
            cur_line      <= cur_line_d;
            cur_fs        <= cur_fs_d;
            o_pix_vld     <= pix_vld_d;
            o_frame_start <= frame_start_d;
            o_line_end    <= line_end_d;
            o_frame_done  <= frame_done_d;
            o_hdr_err     <= hdr_err_d;
            o_len_err     <= len_err_d;
            if (pix_vld_d) begin
                o_pix_data <= s_axi_rx_tdata;
                o_line_idx <= cur_line;
            end
        end
    end

`ifdef ARX_STATS_EN
    // Counters follow the registered pulses, so they lag the event by one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pkt_cnt <= '0;
            o_err_cnt <= '0;
        end else if (i_stats_clr) begin
            o_pkt_cnt <= '0;
            o_err_cnt <= '0;
        end else begin
            if (o_line_end && (o_pkt_cnt != '1))
                o_pkt_cnt <= o_pkt_cnt + 32'd1;
            if ((o_hdr_err || o_len_err || o_seq_err) && (o_err_cnt != '1))
                o_err_cnt <= o_err_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aurora_img_depkt.sv
// Bench for aurora_img_depkt with a reduced frame geometry; packet-level reference model.
module tb_aurora_img_depkt;

    localparam int unsigned H_PIX = 32;
    localparam int HW = 16;
    localparam int VL = 8;
    localparam logic [15:0] SYNC = 16'h5AA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = 4'hF;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        chan_up = 1'b1;
    logic [31:0] o_pix_data;
    logic        o_pix_vld;
    logic [10:0] o_line_idx;
    logic        o_frame_start, o_line_end, o_frame_done, o_hdr_err, o_len_err, o_seq_err;
`ifdef ARX_STATS_EN
    logic        stats_clr = 1'b0;
    logic [31:0] pkt_cnt, err_cnt;
    int          st_pkt = 0, st_err = 0;
`endif

    aurora_img_depkt #(
        .H_PIXELS (H_PIX),
        .V_LINES  (VL),
        .SYNC_WORD(SYNC)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .s_axi_rx_tdata  (tdata),
        .s_axi_rx_tkeep  (tkeep),
        .s_axi_rx_tlast  (tlast),
        .s_axi_rx_tvalid (tvalid),
        .i_channel_up    (chan_up),
        .o_pix_data      (o_pix_data),
        .o_pix_vld       (o_pix_vld),
        .o_line_idx      (o_line_idx),
        .o_frame_start   (o_frame_start),
        .o_line_end      (o_line_end),
        .o_frame_done    (o_frame_done),
        .o_hdr_err       (o_hdr_err),
        .o_len_err       (o_len_err),
        .o_seq_err       (o_seq_err)
`ifdef ARX_STATS_EN
        ,
        .i_stats_clr     (stats_clr),
        .o_pkt_cnt       (pkt_cnt),
        .o_err_cnt       (err_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct packed {
        logic        vld;
        logic [31:0] data;
        logic [10:0] line;
        logic        fs;
        logic        le;
        logic        fd;
        logic        he;
        logic        lerr;
        logic        se;
    } exp_t;

    // drop_kind: 0 = channel down at payload beat drop_at, 1 = reset there
    typedef struct {
        bit sync_ok;
        bit fs;
        int line;
        int n;
        int keep_bad;
        int drop_at;
        int drop_kind;
    } pkt_t;

    typedef struct {
        pkt_t p;
        int pix, fst, le, fd, he, len, se;
    } vec_t;

    exp_t        pend = '0;
    logic [10:0] exp_line = '0;
    int checks = 0, errors = 0;
    int c_pix = 0, c_fs = 0, c_le = 0, c_fd = 0, c_he = 0, c_len = 0, c_se = 0;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic check_out();
        bit bad;
        checks++;
        bad = (o_pix_vld !== pend.vld) || (o_frame_start !== pend.fs) || (o_line_end !== pend.le) ||
              (o_frame_done !== pend.fd) || (o_hdr_err !== pend.he) || (o_len_err !== pend.lerr) ||
              (o_seq_err !== pend.se);
        if (pend.vld && ((o_pix_data !== pend.data) || (o_line_idx !== pend.line)))
            bad = 1'b1;
        if (bad) begin
            errors++;
            $display("FAIL out_cycle @%0t: got vld=%b d=%h ln=%0d fs=%b le=%b fd=%b he=%b len=%b seq=%b, want vld=%b d=%h ln=%0d fs=%b le=%b fd=%b he=%b len=%b seq=%b",
                     $time, o_pix_vld, o_pix_data, o_line_idx, o_frame_start, o_line_end, o_frame_done,
                     o_hdr_err, o_len_err, o_seq_err, pend.vld, pend.data, pend.line, pend.fs, pend.le,
                     pend.fd, pend.he, pend.lerr, pend.se);
        end
        c_pix += int'(o_pix_vld);
        c_fs  += int'(o_frame_start);
        c_le  += int'(o_line_end);
        c_fd  += int'(o_frame_done);
        c_he  += int'(o_hdr_err);
        c_len += int'(o_len_err);
        c_se  += int'(o_seq_err);
`ifdef ARX_STATS_EN
        st_pkt += int'(o_line_end);
        st_err += int'(o_hdr_err | o_len_err | o_seq_err);
`endif
    endtask

    // Check last cycle's outputs, then drive this cycle's inputs and its expected result.
    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] k, input logic l,
                        input logic ch, input logic rn, input exp_t e);
        @(negedge clk);
        check_out();
        tvalid  = v;
        tdata   = d;
        tkeep   = k;
        tlast   = l;
        chan_up = ch;
        rst_n   = rn;
        pend    = e;
`ifdef ARX_STATS_EN
        if (!rn) begin
            st_pkt = 0;
            st_err = 0;
        end
`endif
    endtask

    task automatic idles(input int pct);
        for (int j = 0; j < 3; j++) begin
            if ($urandom_range(99) >= pct) break;
            step(1'b0, $urandom, 4'($urandom), 1'($urandom), 1'b1, 1'b1, '0);
        end
    endtask

    function automatic logic [31:0] payload_word();
        logic [31:0] d;
        d = $urandom;
        if (d[31:16] == SYNC) d[31] = ~d[31];
        return d;
    endfunction

    function automatic pkt_t mk(bit s, bit f, int ln, int n, int kb, int da, int dk);
        pkt_t p;
        p.sync_ok = s; p.fs = f; p.line = ln; p.n = n;
        p.keep_bad = kb; p.drop_at = da; p.drop_kind = dk;
        return p;
    endfunction

    // Expected outcome per packet follows from counts: how many pairs get out, where the
    // single length error lands, and whether the line completes good.
    task automatic send_pkt(input pkt_t p, input int pct);
        int n_emit, err_beat;
        bit keep_hit, good, accepted, killed, after_rst;
        logic [31:0] hdr, d;
        logic [3:0] k;
        exp_t e;

        n_emit   = (p.n < HW) ? p.n : HW;
        keep_hit = (p.keep_bad >= 0) && (p.keep_bad < n_emit);
        if (keep_hit) n_emit = p.keep_bad;
        good     = (p.n == HW) && !keep_hit;
        err_beat = good ? -1 : (keep_hit ? p.keep_bad : n_emit - 1);
        accepted = p.sync_ok && (p.n > 0);
        killed   = 0;
        after_rst = 0;

        hdr = p.sync_ok ? {SYNC, p.fs, 4'($urandom), 11'(p.line)} : {16'h1234, 16'(p.line)};
        e = '0;
        if (!accepted) e.he = 1'b1;
        else           e.se = !p.fs && (11'(p.line) != exp_line);
        idles(pct);
        step(1'b1, hdr, 4'hF, p.n == 0, 1'b1, 1'b1, e);
        if (accepted) exp_line = 11'(p.line);

        for (int i = 0; i < p.n; i++) begin
            if (accepted && i == p.drop_at) begin
                if (p.drop_kind == 0) begin
                    step(1'b0, $urandom, 4'hF, 1'b0, 1'b0, 1'b1, '0);
                    step(1'b0, $urandom, 4'hF, 1'b0, 1'b0, 1'b1, '0);
                    killed = 1;
                    break;
                end
                step(1'b0, $urandom, 4'hF, 1'b0, 1'b1, 1'b0, '0);
                step(1'b0, $urandom, 4'hF, 1'b0, 1'b1, 1'b0, '0);
                exp_line  = '0;
                after_rst = 1;
            end
            idles(pct);
            d = payload_word();
            k = (i == p.keep_bad) ? 4'($urandom_range(14)) : 4'hF;
            e = '0;
            if (after_rst) begin
                e.he = (i == p.drop_at);
            end else if (accepted) begin
                e.vld = (i < n_emit);
                if (e.vld) begin
                    e.data = d;
                    e.line = 11'(p.line);
                    e.fs   = (i == 0) && p.fs && (p.line == 0);
                end
                e.lerr = (i == err_beat);
                e.le   = good && (i == HW - 1);
                e.fd   = e.le && (p.line == VL - 1);
            end
            step(1'b1, d, k, i == p.n - 1, 1'b1, 1'b1, e);
        end

        if (accepted && good && !killed && !after_rst)
            exp_line = (p.line == VL - 1) ? 11'd0 : 11'(p.line + 1);
    endtask

    task automatic flush();
        step(1'b0, '0, 4'hF, 1'b0, 1'b1, 1'b1, '0);
        step(1'b0, '0, 4'hF, 1'b0, 1'b1, 1'b1, '0);
    endtask

    vec_t tbl[15];

    initial begin
        int b_pix, b_fs, b_le, b_fd, b_he, b_len, b_se;
        pkt_t rp;
        int lim, r;

        tbl[0]  = '{mk(1, 1, 0, HW, -1, -1, 0),      16, 1, 1, 0, 0, 0, 0};
        tbl[1]  = '{mk(1, 0, 1, HW, -1, -1, 0),      16, 0, 1, 0, 0, 0, 0};
        tbl[2]  = '{mk(1, 0, 2, 5, -1, -1, 0),        5, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{mk(1, 0, 2, HW, -1, -1, 0),      16, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{mk(0, 0, 5, 5, -1, -1, 0),        0, 0, 0, 0, 1, 0, 0};
        tbl[5]  = '{mk(1, 0, 3, HW, -1, -1, 0),      16, 0, 1, 0, 0, 0, 0};
        tbl[6]  = '{mk(1, 0, 5, HW, -1, -1, 0),      16, 0, 1, 0, 0, 0, 1};
        tbl[7]  = '{mk(1, 0, 6, HW, -1, -1, 0),      16, 0, 1, 0, 0, 0, 0};
        tbl[8]  = '{mk(1, 0, 7, HW, -1, -1, 0),      16, 0, 1, 1, 0, 0, 0};
        tbl[9]  = '{mk(1, 0, 0, HW, -1, -1, 0),      16, 0, 1, 0, 0, 0, 0};
        tbl[10] = '{mk(1, 0, 1, HW, 4, -1, 0),        4, 0, 0, 0, 0, 1, 0};
        tbl[11] = '{mk(1, 0, 1, HW + 4, -1, -1, 0),  16, 0, 0, 0, 0, 1, 0};
        tbl[12] = '{mk(1, 0, 1, 0, -1, -1, 0),        0, 0, 0, 0, 1, 0, 0};
        tbl[13] = '{mk(1, 0, 1, HW, -1, 7, 0),        7, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{mk(1, 0, 1, HW, -1, -1, 0),      16, 0, 1, 0, 0, 0, 0};

        for (int i = 0; i < 3; i++)
            step(1'b0, '0, 4'hF, 1'b0, 1'b1, 1'b0, '0);

        for (int v = 0; v < 15; v++) begin
            b_pix = c_pix; b_fs = c_fs; b_le = c_le; b_fd = c_fd;
            b_he = c_he; b_len = c_len; b_se = c_se;
            send_pkt(tbl[v].p, 0);
            flush();
            chk($sformatf("vec%0d pix", v),         c_pix - b_pix, tbl[v].pix);
            chk($sformatf("vec%0d frame_start", v), c_fs - b_fs,   tbl[v].fst);
            chk($sformatf("vec%0d line_end", v),    c_le - b_le,   tbl[v].le);
            chk($sformatf("vec%0d frame_done", v),  c_fd - b_fd,   tbl[v].fd);
            chk($sformatf("vec%0d hdr_err", v),     c_he - b_he,   tbl[v].he);
            chk($sformatf("vec%0d len_err", v),     c_len - b_len, tbl[v].len);
            chk($sformatf("vec%0d seq_err", v),     c_se - b_se,   tbl[v].se);
        end

        // Full frame, then a plain line 0 must not look out of sequence.
        b_fd = c_fd; b_le = c_le; b_se = c_se; b_fs = c_fs;
        for (int l = 0; l < VL; l++)
            send_pkt(mk(1, l == 0, l, HW, -1, -1, 0), 0);
        flush();
        chk("frame frame_done", c_fd - b_fd, 1);
        chk("frame line_end",   c_le - b_le, VL);
        chk("frame frame_start", c_fs - b_fs, 1);
        chk("frame seq_err",    c_se - b_se, 0);
        b_se = c_se; b_le = c_le;
        send_pkt(mk(1, 0, 0, HW, -1, -1, 0), 0);
        flush();
        chk("post-frame seq_err",  c_se - b_se, 0);
        chk("post-frame line_end", c_le - b_le, 1);

        // Reset in the middle of line 1: remainder is a sync mismatch, expected line returns to 0.
        b_pix = c_pix; b_he = c_he; b_le = c_le;
        send_pkt(mk(1, 0, 1, HW, -1, 6, 1), 0);
        flush();
        chk("rst-mid pix",      c_pix - b_pix, 6);
        chk("rst-mid hdr_err",  c_he - b_he,   1);
        chk("rst-mid line_end", c_le - b_le,   0);
        b_se = c_se;
        send_pkt(mk(1, 0, 0, HW, -1, -1, 0), 0);
        flush();
        chk("post-rst seq_err", c_se - b_se, 0);

        for (int t = 0; t < 200; t++) begin
            rp.sync_ok = ($urandom_range(99) >= 8);
            rp.fs      = ($urandom_range(99) < 12);
            r = $urandom_range(99);
            if (r < 70)      rp.line = int'(exp_line);
            else if (r < 90) rp.line = $urandom_range(VL - 1);
            else             rp.line = $urandom_range(2047);
            rp.n = ($urandom_range(99) < 75) ? HW : $urandom_range(HW + 4);
            lim = (rp.n < HW) ? rp.n : HW;
            rp.keep_bad = -1;
            if (lim > 0 && $urandom_range(99) < 10) begin
                rp.keep_bad = $urandom_range(lim - 1);
                lim = rp.keep_bad;
            end
            rp.drop_at = -1;
            rp.drop_kind = 0;
            r = $urandom_range(99);
            if (lim > 0 && r < 8) begin
                rp.drop_at = $urandom_range(lim - 1);
                rp.drop_kind = (r < 5) ? 0 : 1;
            end
            send_pkt(rp, 25);
        end
        flush();

`ifdef ARX_STATS_EN
        chk("stats pkt_cnt", int'(pkt_cnt), st_pkt);
        chk("stats err_cnt", int'(err_cnt), st_err);
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        chk("stats clr pkt", int'(pkt_cnt), 0);
        chk("stats clr err", int'(err_cnt), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
